// File: rtl/pdm_loudness_detector.sv
// PDM mic front end: generates mic_clk, decimates the 1-bit stream into PCM windows,
// sums window deviations into a loudness envelope and drives jump through hysteresis.
module pdm_loudness_detector #(
    parameter int CLK_DIV = 18,
    parameter int WINDOW  = 128,
    parameter int ENV_WIN = 16,
    parameter int TH_ON   = 300,
    parameter int TH_OFF  = 150
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       micdata,
    output logic                       mic_clk,
    output logic                       mic_lr,
    output logic [$clog2(WINDOW):0]    pcm,
    output logic                       pcm_valid,
    output logic [15:0]                level,
    output logic                       level_valid,
    output logic [3:0]                 jump
);

    localparam int W     = $clog2(WINDOW);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW    = (ENV_WIN > 1) ? $clog2(ENV_WIN) : 1;

    localparam logic [1:0] WARM  = 2'd0;
    localparam logic [1:0] QUIET = 2'd1;
    localparam logic [1:0] LOUD  = 2'd2;

    localparam logic [W:0] HALF = (W+1)'(WINDOW / 2);

    logic [DIV_W-1:0] div_cnt;
    logic             mic_meta;
    logic             mic_s;
    logic             strobe;
    logic [W-1:0]     bit_cnt;
    logic [W-1:0]     ones_cnt;
    logic [W:0]       dev;
    logic [15:0]      env_acc;
    logic [EW-1:0]    win_idx;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             loud;

    assign mic_lr = 1'b0;
    assign jump   = {3'b000, loud};

    // Free-running divider; en deliberately does not stop the microphone clock.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mic_meta <= 1'b0;
            mic_s    <= 1'b0;
        end else begin
            mic_meta <= micdata;
            mic_s    <= mic_meta;
        end
    end

    // Data is taken on the cycle mic_clk is about to fall.
    assign strobe = (div_cnt == DIV_W'(CLK_DIV - 1)) && mic_clk;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (!en) begin
                bit_cnt  <= '0;
                ones_cnt <= '0;
            end else if (strobe) begin
                if (bit_cnt == W'(WINDOW - 1)) begin
                    pcm       <= {1'b0, ones_cnt} + (W+1)'(mic_s);
                    pcm_valid <= 1'b1;
                    bit_cnt   <= '0;
                    ones_cnt  <= '0;
                end else begin
                    bit_cnt  <= bit_cnt + W'(1);
                    ones_cnt <= ones_cnt + W'(mic_s);
                end
            end
        end
    end

    assign dev = (pcm >= HALF) ? (pcm - HALF) : (HALF - pcm);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            env_acc     <= '0;
            win_idx     <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (!en) begin
                env_acc <= '0;
                win_idx <= '0;
            end else if (pcm_valid) begin
                if (win_idx == EW'(ENV_WIN - 1)) begin
                    level       <= env_acc + 16'(dev);
                    level_valid <= 1'b1;
                    env_acc     <= '0;
                    win_idx     <= '0;
                end else begin
                    env_acc <= env_acc + 16'(dev);
                    win_idx <= win_idx + EW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WARM:    state_nxt = QUIET;
            QUIET:   if (level >= 16'(TH_ON))  state_nxt = LOUD;
            LOUD:    if (level <  16'(TH_OFF)) state_nxt = QUIET;
            default: state_nxt = WARM;
        endcase
    end

    // The first level after reset or enable only moves WARM to QUIET.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= WARM;
            loud  <= 1'b0;
        end else if (!en) begin
            state <= WARM;
            loud  <= 1'b0;
        end else if (level_valid) begin
            state <= state_nxt;
            loud  <= (state_nxt == LOUD);
        end
    end

endmodule
